keyboard_input_controller: RTL

Sequences PS/2 Set 2 scan bytes into hexadecimal operands for the processor's keyboard input instruction. Sits between the PS/2 byte receiver and the processor input port. Filters break and extended prefixes and passes make codes through the `scancode_decoder` combinational translator. Accumulates hex digits until Enter, then holds the assembled value behind a valid/ready handshake.

---
 rtl/kbd_pkg.sv | 27 ++
 rtl/scancode_decoder.sv | 38 +++
 rtl/keyboard_input_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared constants, FSM state type and hex helpers for the keyboard input controller.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;

    typedef enum logic {
        S_ACC,
        S_HOLD
    } kbd_state_t;

    function automatic logic is_hex_ascii(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    // Letters 'A'-'F' have low nibble 1-6, so they need +9 to land on 10-15.
    function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
        if (c >= 8'h41) begin
            return c[3:0] + 4'd9;
        end
        return c[3:0];
    endfunction

endpackage

// File: rtl/scancode_decoder.sv
// Combinational PS/2 Set 2 make-code translator: hex digits and Enter to ASCII, 0 otherwise.
module scancode_decoder
    import kbd_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] scan_code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (scan_code)
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h1C: ascii = 8'h41;
            8'h32: ascii = 8'h42;
            8'h21: ascii = 8'h43;
            8'h23: ascii = 8'h44;
            8'h24: ascii = 8'h45;
            8'h2B: ascii = 8'h46;
            8'h5A: ascii = ASCII_CR;
            default: ascii = 8'h00;
        endcase
    end

    // The translator only ever produces a hex character, CR, or nothing.
    ascii_range_a: assert property (@(posedge clk)
        (ascii == 8'h00) || is_hex_ascii(ascii) || (ascii == ASCII_CR));

endmodule

// File: rtl/keyboard_input_controller.sv
// Assembles PS/2 hex keystrokes into an operand behind a valid/ready handshake.
// Optional auto-repeat suppression: define KBD_CTRL_TYPEMATIC_FILTER_EN.
module keyboard_input_controller
    import kbd_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int MAX_DIGITS = 8,
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_valid,
    input  logic [7:0]        scan_code,
    input  logic              value_ready,
    output logic              value_valid,
    output logic [DATA_W-1:0] value_out,
    output logic [CNT_W-1:0]  digit_count,
    output logic              char_valid,
    output logic [7:0]        char_out
);

    kbd_state_t        state;
    logic [DATA_W-1:0] acc;
    logic              brk;
    logic              ext;
    logic [7:0]        dec_ascii;
    logic              is_prefix;
    logic              is_make;
    logic              accept_make;
    logic              key_digit;
    logic              key_enter;
    logic              key_bksp;

    scancode_decoder u_decoder (
        .clk       (clk),
        .scan_code (scan_code),
        .ascii     (dec_ascii)
    );

    assign is_prefix = (scan_code == SC_BREAK) || (scan_code == SC_EXT);
    assign is_make   = scan_valid && !is_prefix && !brk && !ext;
    assign key_digit = is_hex_ascii(dec_ascii);
    assign key_enter = (dec_ascii == ASCII_CR);
    assign key_bksp  = (scan_code == SC_BKSP);
    assign value_out = acc;

    // Prefix flags swallow exactly one following byte, whatever the FSM is doing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (scan_valid) begin
            if (scan_code == SC_BREAK) begin
                brk <= 1'b1;
            end else if (scan_code == SC_EXT) begin
                ext <= 1'b1;
            end else begin
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

`ifdef KBD_CTRL_TYPEMATIC_FILTER_EN
    logic [7:0] last_make;

    assign accept_make = is_make && (scan_code != last_make);

    // 8'h00 is never a real key, so it doubles as the "no key held" marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_make <= 8'h00;
        end else if (is_make) begin
            last_make <= scan_code;
        end else if (scan_valid && brk && !is_prefix && (scan_code == last_make)) begin
            last_make <= 8'h00;
        end
    end
`else
    assign accept_make = is_make;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_ACC;
            acc         <= '0;
            digit_count <= '0;
            value_valid <= 1'b0;
            char_valid  <= 1'b0;
            char_out    <= 8'h00;
        end else begin
            char_valid <= 1'b0;
            case (state)
                S_ACC: begin
                    if (accept_make) begin
                        if (key_digit) begin
                            if (digit_count < CNT_W'(MAX_DIGITS)) begin
                                acc         <= {acc[DATA_W-5:0], hex_to_nibble(dec_ascii)};
                                digit_count <= digit_count + CNT_W'(1);
                                char_valid  <= 1'b1;
                                char_out    <= dec_ascii;
                            end
                        end else if (key_bksp) begin
                            if (digit_count != '0) begin
                                acc         <= acc >> 4;
                                digit_count <= digit_count - CNT_W'(1);
                                char_valid  <= 1'b1;
                                char_out    <= ASCII_BS;
                            end
                        end else if (key_enter) begin
                            if (digit_count != '0) begin
                                state       <= S_HOLD;
                                value_valid <= 1'b1;
                                char_valid  <= 1'b1;
                                char_out    <= ASCII_CR;
                            end
                        end
                    end
                end
                // Keystrokes arriving while the operand waits are deliberately lost.
                S_HOLD: begin
                    if (value_ready) begin
                        state       <= S_ACC;
                        acc         <= '0;
                        digit_count <= '0;
                        value_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_ACC;
                    value_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
